seq_monitor: RTL
================

Name: seq_monitor

Overview:
- Sits directly downstream of the sequence controller top level. Consumes its 7-bit one-hot phase vector p[0:6] and its group flags c1/c2.
- Registers and encodes the active phase, pulses on every phase change, and measures dwell time per phase and total transitions.
- Flags illegal multi-hot patterns, group-flag inconsistencies, and phases that stall too long.
- Feeds status and debug logic; it never drives the controller.

Parameters:
- DWELL_W, 8: width of the dwell counter; saturates at 2^DWELL_W-1.
- CNT_W, 8: width of the transition counter; saturates at 2^CNT_W-1.
- TIMEOUT, 200: dwell cycles in one valid phase before stall asserts. Legal range is 1..2^DWELL_W-1; elaboration must fail outside it.

Ports:
- ck, in, 1: clock, rising edge.
- rs, in, 1: asynchronous active-low reset.
- p, in, [0:6]: phase vector from the controller; combinational at the source.
- c1, in, 1: controller group flag, expected to equal p[1]|p[5]|p[6].
- c2, in, 1: controller group flag, expected to equal p[0]|p[2]|p[4].
- clr, in, 1: synchronous clear of statistics and sticky flags.
- state, out, 3: encoded phase 0..6; 7 means idle or invalid.
- valid, out, 1: state holds a legal single phase.
- chg, out, 1: one-cycle pulse when the encoded phase changes.
- dwell, out, DWELL_W: cycles spent in the current code.
- trans, out, CNT_W: number of code changes since reset or clr.
- err, out, 1: sticky flag, multi-hot p seen.
- grp_err, out, 1: sticky flag, c1/c2 inconsistent with p.
- stall, out, 1: level, asserted while valid and dwell >= TIMEOUT.

Behaviour:
- Clock and reset
  - Single clock ck; rs is asynchronous and active-low.
  - While rs=0: input stage cleared to zero, state=7, valid=0, chg=0, dwell=0, trans=0, err=0, grp_err=0, stall=0, internal previous code=7.
  - Reset takes effect mid-operation with no drain. Counting restarts from 0 after release.
- Stage 1 (input capture)
  - p, c1 and c2 are registered every cycle.
  - No combinational path from any input to any output.
- Stage 2 (decode and statistics)
  - Decode the registered p:
    - Exactly one bit k set: code=k, valid=1.
    - All zero: code=7, valid=0, not an error. This is the controller's idle/unused decode.
    - Two or more bits set: code=7, valid=0, err set sticky.
  - Group check, on the registered values: grp_err is set sticky if c1 != (p[1]|p[5]|p[6]) or c2 != (p[0]|p[2]|p[4]). The check applies to every pattern, including multi-hot.
  - Latency: an input change on the cycle before edge n appears on state/valid/chg at edge n+1, i.e. 2 cycles.
  - chg=1 for exactly one cycle when the new code != previous code. Idle/invalid counts as code 7, so 3->7 and 7->3 both pulse, but multi-hot following idle does not.
  - On chg: dwell loads 0 and trans increments, saturating, with no wrap.
  - Without chg: dwell increments, saturating at 2^DWELL_W-1.
  - stall = valid && (dwell >= TIMEOUT), evaluated from the registered outputs.
  - First decode after reset compares against previous code 7, so an idle input gives no chg.
- clr
  - Takes effect at the edge where it is sampled high.
  - Clears dwell, trans, err and grp_err.
  - Does not alter state, valid, chg or the pipeline.
  - Priority over same-cycle events: clr beats chg increment (trans=0), clr beats an error detect (flag stays 0 that cycle and may set on the next detect), clr beats dwell increment (dwell=0).
- Width and arithmetic
  - All counters are unsigned.
  - Saturation is held until chg, clr or reset.

Test Plan:
1. Reset then idle: rs low for 3 cycles, then high, with p=0 and c1=c2=0 → state=7, valid=0, chg never pulses, dwell counts 0,1,2…, err=grp_err=0.
2. Phase walk: p one-hot 0→1→5, 4 cycles each, c1/c2 consistent → state 0,1,5 each 2 cycles after the input; chg pulses 3 times, 4 cycles apart; dwell reaches 3 before each reset to 0; trans=3.
3. Stall and saturation: TIMEOUT=5, DWELL_W=3, hold p=7'b0010000 → stall rises when dwell=5; dwell sticks at 7; stall stays 1. Drop to p=0 → stall=0.
4. Illegal pattern: p=7'b1100000 for 1 cycle between valid phases → state=7 and valid=0 for 1 cycle, err=1 and stays 1 after p recovers; clr pulse → err=0.
5. Group mismatch: p=7'b0100000 with c1=0 → grp_err=1 two cycles later. Same p with c1=1 after clr → grp_err remains 0.
6. Collisions: clr coincident with chg → trans=0, dwell=0, chg still pulses. Assert rs mid-phase with trans=9 → all outputs reach reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/seq_monitor.sv
// -----------------------------------------------------------------------------
// seq_monitor
//
// Passive observer for the sequence controller. It registers the controller's
// one-hot phase vector and group flags, encodes the active phase, pulses on
// every phase change, and keeps per-phase dwell and total transition counts.
// It also flags multi-hot phase patterns, group-flag inconsistencies and
// phases that are held for too long. It never drives the controller.
//
// Parameters
//   DWELL_W : width of the dwell counter (saturating)
//   CNT_W   : width of the transition counter (saturating)
//   TIMEOUT : dwell cycles in one valid phase before stall asserts,
//             legal range 1 .. 2**DWELL_W-1
//
// Ports
//   ck      in   clock, rising edge
//   rs      in   asynchronous active-low reset
//   p       in   [0:6] phase vector from the controller
//   c1      in   group flag, expected p[1]|p[5]|p[6]
//   c2      in   group flag, expected p[0]|p[2]|p[4]
//   clr     in   synchronous clear of statistics and sticky flags
//   state   out  encoded phase 0..6, 7 = idle or invalid
//   valid   out  state holds a legal single phase
//   chg     out  one-cycle pulse when the encoded phase changes
//   dwell   out  cycles spent in the current code
//   trans   out  code changes since reset or clr
//   err     out  sticky, multi-hot p seen
//   grp_err out  sticky, c1/c2 inconsistent with p
//   stall   out  level, valid and dwell >= TIMEOUT
// -----------------------------------------------------------------------------
module seq_monitor #(
   parameter int DWELL_W = 8,
   parameter int CNT_W   = 8,
   parameter int TIMEOUT = 200
) (
   input  logic               ck,
   input  logic               rs,
   input  logic [0:6]         p,
   input  logic               c1,
   input  logic               c2,
   input  logic               clr,
   output logic [2:0]         state,
   output logic               valid,
   output logic               chg,
   output logic [DWELL_W-1:0] dwell,
   output logic [CNT_W-1:0]   trans,
   output logic               err,
   output logic               grp_err,
   output logic               stall
);

   // Refuse to elaborate with a threshold the dwell counter can never reach.
   if ((TIMEOUT < 1) || (TIMEOUT > ((2 ** DWELL_W) - 1))) begin : g_bad_timeout
      $error("seq_monitor: TIMEOUT out of range 1..2**DWELL_W-1");
   end

   localparam logic [2:0]         CODE_IDLE = 3'd7;
   localparam logic [DWELL_W-1:0] DWELL_MAX = '1;
   localparam logic [DWELL_W-1:0] DWELL_ONE = {{(DWELL_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0]   CNT_MAX   = '1;
   localparam logic [CNT_W-1:0]   CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [DWELL_W-1:0] TIMEOUT_V = DWELL_W'(TIMEOUT);

   // Stage 1 registers
   logic [0:6]         r_p;
   logic               r_c1;
   logic               r_c2;

   // Stage 2 registers; r_state doubles as the previous code for chg
   logic [2:0]         r_state;
   logic               r_valid;
   logic               r_chg;
   logic [DWELL_W-1:0] r_dwell;
   logic [CNT_W-1:0]   r_trans;
   logic               r_err;
   logic               r_grp_err;

   // Decode results
   logic [2:0]         w_code;
   logic [2:0]         w_count;
   logic               w_one;
   logic               w_multi;
   logic [2:0]         w_next_code;
   logic               w_chg;
   logic               w_grp_bad;

   // Input capture stage: no input reaches an output combinationally.
   always_ff @(posedge ck or negedge rs) begin
      if (!rs) begin
         r_p  <= 7'b0000000;
         r_c1 <= 1'b0;
         r_c2 <= 1'b0;
      end else begin
         r_p  <= p;
         r_c1 <= c1;
         r_c2 <= c2;
      end
   end

   // Population count and index of the set bit of the registered phase vector.
   always_comb begin
      w_code  = CODE_IDLE;
      w_count = 3'd0;
      for (int i = 0; i < 7; i++) begin
         if (r_p[i]) begin
            w_code  = 3'(i);
            w_count = w_count + 3'd1;
         end else begin
            w_count = w_count;
         end
      end
   end

   assign w_one       = (w_count == 3'd1);
   assign w_multi     = (w_count > 3'd1);
   // Idle and multi-hot both encode as 7, so multi-hot after idle is no change.
   assign w_next_code = w_one ? w_code : CODE_IDLE;
   assign w_chg       = (w_next_code != r_state);
   assign w_grp_bad   = (r_c1 != (r_p[1] | r_p[5] | r_p[6])) ||
                        (r_c2 != (r_p[0] | r_p[2] | r_p[4]));

   // Decode, change detect, statistics and sticky flags; clr wins over events.
   always_ff @(posedge ck or negedge rs) begin
      if (!rs) begin
         r_state   <= CODE_IDLE;
         r_valid   <= 1'b0;
         r_chg     <= 1'b0;
         r_dwell   <= '0;
         r_trans   <= '0;
         r_err     <= 1'b0;
         r_grp_err <= 1'b0;
      end else begin
         r_state <= w_next_code;
         r_valid <= w_one;
         r_chg   <= w_chg;
         if (clr) begin
            r_dwell   <= '0;
            r_trans   <= '0;
            r_err     <= 1'b0;
            r_grp_err <= 1'b0;
         end else begin
            if (w_chg) begin
               r_dwell <= '0;
            end else if (r_dwell != DWELL_MAX) begin
               r_dwell <= r_dwell + DWELL_ONE;
            end
            if (w_chg && (r_trans != CNT_MAX)) begin
               r_trans <= r_trans + CNT_ONE;
            end
            if (w_multi) begin
               r_err <= 1'b1;
            end
            if (w_grp_bad) begin
               r_grp_err <= 1'b1;
            end
         end
      end
   end

   assign state   = r_state;
   assign valid   = r_valid;
   assign chg     = r_chg;
   assign dwell   = r_dwell;
   assign trans   = r_trans;
   assign err     = r_err;
   assign grp_err = r_grp_err;
   // Derived only from registered outputs, so it tracks dwell in the same cycle.
   assign stall   = r_valid && (r_dwell >= TIMEOUT_V);

endmodule
